// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and elaboration helpers for the convolution frame sequencer
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_e;

  function automatic int calcAw(input int xs);
    return (xs > 2) ? $clog2(xs) : 1;
  endfunction

  function automatic int calcRw(input int ws);
    return (ws > 2) ? $clog2(ws) : 1;
  endfunction

  // Output map side length; elaboration-time only, never used on live coordinates.
  function automatic int calcOd(input int xs, input int ws, input int stride);
    return (xs - ws) / stride + 1;
  endfunction

endpackage

// File: rtl/win_axis_cnt.sv
// rtl/win_axis_cnt.sv - one axis of window tracking: position, next target and output index
module win_axis_cnt #(
  parameter int N      = 32,
  parameter int WS     = 5,
  parameter int STRIDE = 1,
  parameter int AW     = 5
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iClr,
  input  logic          iInc,
  input  logic          iAdv,
  input  logic          iRewind,
  output logic [AW-1:0] oPos,
  output logic [AW-1:0] oIdx,
  output logic          oHit
);

  localparam logic [AW:0]   TGT_INIT = (AW+1)'(WS - 1);
  localparam logic [AW:0]   TGT_STEP = (AW+1)'(STRIDE);
  localparam logic [AW-1:0] POS_LAST = AW'(N - 1);

  logic [AW-1:0] pos;
  logic [AW-1:0] idx;
  // One extra bit so a target stepped past the edge stays out of reach instead of aliasing.
  logic [AW:0]   tgt;

  assign oPos = pos;
  assign oIdx = idx;
  assign oHit = ({1'b0, pos} == tgt);

  always_ff @(posedge iCLK) begin
    if (!iRSTn || iClr) begin
      pos <= '0;
      idx <= '0;
      tgt <= TGT_INIT;
    end else begin
      if (iInc) begin
        pos <= (pos == POS_LAST) ? '0 : pos + AW'(1);
      end
      // A hit on the last column coincides with the row wrap; the wrap wins.
      if (iRewind) begin
        tgt <= TGT_INIT;
        idx <= '0;
      end else if (iAdv) begin
        tgt <= tgt + TGT_STEP;
        idx <= idx + AW'(1);
      end
    end
  end

endmodule

// File: rtl/conv_frame_seq.sv
// rtl/conv_frame_seq.sv - start/busy/done frame sequencer driving line-buffer writes and window strobes
module conv_frame_seq
  import conv_pkg::*;
#(
  parameter int XS     = 32,
  parameter int WS     = 5,
  parameter int STRIDE = 1,
  parameter int AW     = calcAw(XS),
  parameter int RW     = calcRw(WS)
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iStart,
  input  logic          iValid,
  output logic          oReady,
  input  logic          iStall,
  output logic          oLbWe,
  output logic [AW-1:0] oLbAddr,
  output logic [RW-1:0] oLbRow,
  output logic          oWinValid,
  output logic [AW-1:0] oOutRow,
  output logic [AW-1:0] oOutCol,
  output logic          oBusy,
  output logic          oDone
);

  localparam logic [AW-1:0] POS_LAST = AW'(XS - 1);
  localparam logic [RW-1:0] LBR_LAST = RW'(WS - 1);

  seqState_e     state;
  logic          accept;
  logic          startFrame;
  logic          colLast;
  logic          rowLast;
  logic          colHit;
  logic          rowHit;
  logic          winHit;
  logic [AW-1:0] colPos;
  logic [AW-1:0] rowPos;
  logic [AW-1:0] colIdx;
  logic [AW-1:0] rowIdx;

  assign oReady     = (state == RUN) && !iStall;
  assign accept     = iValid && oReady;
  assign oLbWe      = accept;
  assign oLbAddr    = colPos;
  assign oBusy      = (state != IDLE);
  assign oDone      = (state == DONE);
  assign startFrame = (state == IDLE) && iStart;
  assign colLast    = (colPos == POS_LAST);
  assign rowLast    = (rowPos == POS_LAST);
  assign winHit     = accept && rowHit && colHit;

  win_axis_cnt #(.N(XS), .WS(WS), .STRIDE(STRIDE), .AW(AW)) uColAxis (
    .iCLK    (iCLK),
    .iRSTn   (iRSTn),
    .iClr    (startFrame),
    .iInc    (accept),
    .iAdv    (winHit),
    .iRewind (accept && colLast),
    .oPos    (colPos),
    .oIdx    (colIdx),
    .oHit    (colHit)
  );

  win_axis_cnt #(.N(XS), .WS(WS), .STRIDE(STRIDE), .AW(AW)) uRowAxis (
    .iCLK    (iCLK),
    .iRSTn   (iRSTn),
    .iClr    (startFrame),
    .iInc    (accept && colLast),
    .iAdv    (accept && colLast && rowHit),
    .iRewind (1'b0),
    .oPos    (rowPos),
    .oIdx    (rowIdx),
    .oHit    (rowHit)
  );

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (iStart) state <= RUN;
        RUN:     if (accept && colLast && rowLast) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Physical line-buffer row rotates through WS slots as input rows complete.
  always_ff @(posedge iCLK) begin
    if (!iRSTn || startFrame) begin
      oLbRow <= '0;
    end else if (accept && colLast) begin
      oLbRow <= (oLbRow == LBR_LAST) ? '0 : oLbRow + RW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      oWinValid <= 1'b0;
      oOutRow   <= '0;
      oOutCol   <= '0;
    end else begin
      oWinValid <= winHit;
      if (winHit) begin
        oOutRow <= rowIdx;
        oOutCol <= colIdx;
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_seq.sv
// tb/tb_conv_frame_seq.sv - directed bench for conv_frame_seq across three window geometries
module tb_conv_frame_seq;

  typedef struct {
    int dut;
    int r;
    int c;
    int pix;
    int done;
  } win_t;

  logic       iCLK = 1'b0;
  logic       iRSTn = 1'b0;
  logic       iStart = 1'b0;
  logic       iValid = 1'b0;
  logic       iStall = 1'b0;
  logic       oReady[3];
  logic       oLbWe[3];
  logic       oWinValid[3];
  logic       oBusy[3];
  logic       oDone[3];
  logic [2:0] oLbAddr[3];
  logic [2:0] oOutRow[3];
  logic [2:0] oOutCol[3];
  logic [1:0] oLbRow[3];

  int   vecCnt = 0;
  int   errCnt = 0;
  win_t winQ[$];
  int   lbRows[$];
  int   stallViol;
  int   doneAcc;

  always #5 iCLK = ~iCLK;

  conv_frame_seq #(.XS(8), .WS(3), .STRIDE(1)) uDut0 (
    .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iValid(iValid), .oReady(oReady[0]),
    .iStall(iStall), .oLbWe(oLbWe[0]), .oLbAddr(oLbAddr[0]), .oLbRow(oLbRow[0]),
    .oWinValid(oWinValid[0]), .oOutRow(oOutRow[0]), .oOutCol(oOutCol[0]),
    .oBusy(oBusy[0]), .oDone(oDone[0])
  );

  conv_frame_seq #(.XS(8), .WS(3), .STRIDE(2)) uDut1 (
    .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iValid(iValid), .oReady(oReady[1]),
    .iStall(iStall), .oLbWe(oLbWe[1]), .oLbAddr(oLbAddr[1]), .oLbRow(oLbRow[1]),
    .oWinValid(oWinValid[1]), .oOutRow(oOutRow[1]), .oOutCol(oOutCol[1]),
    .oBusy(oBusy[1]), .oDone(oDone[1])
  );

  conv_frame_seq #(.XS(8), .WS(4), .STRIDE(3)) uDut2 (
    .iCLK(iCLK), .iRSTn(iRSTn), .iStart(iStart), .iValid(iValid), .oReady(oReady[2]),
    .iStall(iStall), .oLbWe(oLbWe[2]), .oLbAddr(oLbAddr[2]), .oLbRow(oLbRow[2]),
    .oWinValid(oWinValid[2]), .oOutRow(oOutRow[2]), .oOutCol(oOutCol[2]),
    .oBusy(oBusy[2]), .oDone(oDone[2])
  );

  task automatic chkVec(input string tag, input int got, input int exp);
    vecCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chkIdleOutputs(input string tag);
    chkVec({tag, "_ready"}, oReady[0], 0);
    chkVec({tag, "_lbWe"}, oLbWe[0], 0);
    chkVec({tag, "_lbAddr"}, oLbAddr[0], 0);
    chkVec({tag, "_lbRow"}, oLbRow[0], 0);
    chkVec({tag, "_winValid"}, oWinValid[0], 0);
    chkVec({tag, "_outRow"}, oOutRow[0], 0);
    chkVec({tag, "_outCol"}, oOutCol[0], 0);
    chkVec({tag, "_busy"}, oBusy[0], 0);
    chkVec({tag, "_done"}, oDone[0], 0);
  endtask

  // Expected windows: raster order over the OD x OD output map, each strobed after
  // the pixel at input (WS-1+r*S, WS-1+c*S) on an 8-wide frame.
  task automatic checkWins(input string tag, input int k, input int ws, input int st, input int od);
    int n = 0;
    int lastDone = 0;
    int er;
    int ec;
    foreach (winQ[i]) begin
      if (winQ[i].dut == k) begin
        if (n < od * od) begin
          er = n / od;
          ec = n % od;
          chkVec($sformatf("%s_d%0d_w%0d_row", tag, k, n), winQ[i].r, er);
          chkVec($sformatf("%s_d%0d_w%0d_col", tag, k, n), winQ[i].c, ec);
          chkVec($sformatf("%s_d%0d_w%0d_pix", tag, k, n), winQ[i].pix,
                 (ws - 1 + er * st) * 8 + ws - 1 + ec * st);
        end
        lastDone = winQ[i].done;
        n++;
      end
    end
    chkVec($sformatf("%s_d%0d_count", tag, k), n, od * od);
    if (k == 0) chkVec($sformatf("%s_lastWinWithDone", tag), lastDone, 1);
  endtask

  task automatic runFrame(input bit gaps, input int abortAt);
    int accIdx = 0;
    int prevAcc = -1;
    int stallLeft = 0;
    bit fin = 0;
    bit aborted = 0;
    win_t w;
    winQ.delete();
    lbRows.delete();
    stallViol = 0;
    doneAcc = -1;
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
    chkVec("busyAfterStart", oBusy[0], 1);
    chkVec("readyAfterStart", oReady[0], 1);
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (gaps) begin
        iValid = ($urandom_range(0, 3) != 0);
        iStart = ($urandom_range(0, 5) == 0);
        if (stallLeft > 0) begin
          iStall = 1'b1;
          stallLeft--;
        end else begin
          iStall = 1'b0;
          if ($urandom_range(0, 7) == 0) stallLeft = $urandom_range(1, 4);
        end
      end else begin
        iValid = 1'b1;
        iStall = 1'b0;
      end
      if (abortAt >= 0 && accIdx == abortAt) iRSTn = 1'b0;
      @(negedge iCLK);
      for (int k = 0; k < 3; k++) begin
        if (oWinValid[k]) begin
          w.dut = k; w.r = oOutRow[k]; w.c = oOutCol[k]; w.pix = prevAcc; w.done = oDone[k];
          winQ.push_back(w);
        end
      end
      if (oDone[0]) begin
        doneAcc = prevAcc;
        fin = 1'b1;
      end
      if (oLbWe[0]) begin
        if (oLbAddr[0] == 0) lbRows.push_back(oLbRow[0]);
        if (iStall) stallViol++;
        prevAcc = accIdx;
        accIdx++;
      end else begin
        prevAcc = -1;
      end
      if (!iRSTn) begin
        @(negedge iCLK);
        chkIdleOutputs("midReset");
        iRSTn = 1'b1;
        fin = 1'b1;
        aborted = 1'b1;
        @(posedge iCLK);
        #1;
      end else begin
        @(posedge iCLK);
        #1;
      end
    end
    if (!fin) chkVec("frameTimeout", 0, 1);
    if (!aborted && abortAt >= 0) chkVec("abortReached", 0, 1);
    iStart = 1'b0;
    iValid = 1'b0;
    iStall = 1'b0;
  endtask

  task automatic checkFrame(input string tag);
    checkWins(tag, 0, 3, 1, 6);
    checkWins(tag, 1, 3, 2, 3);
    checkWins(tag, 2, 4, 3, 2);
    chkVec({tag, "_doneAfterLastAccept"}, doneAcc, 63);
    chkVec({tag, "_lbRowCount"}, lbRows.size(), 8);
    foreach (lbRows[i]) chkVec($sformatf("%s_lbRow%0d", tag, i), lbRows[i], i % 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    iRSTn = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    iValid = 1'b1;
    @(negedge iCLK);
    chkIdleOutputs("reset");
    iRSTn = 1'b1;
    @(posedge iCLK);
    #1;
    @(negedge iCLK);
    chkVec("idleNoAccept", oLbWe[0], 0);
    @(posedge iCLK);
    #1;
    iValid = 1'b0;

    runFrame(1'b0, -1);
    checkFrame("cont");

    runFrame(1'b1, -1);
    checkFrame("gaps");
    chkVec("gaps_acceptUnderStall", stallViol, 0);

    runFrame(1'b0, -1);
    checkFrame("backToBack");

    runFrame(1'b0, 30);
    runFrame(1'b0, -1);
    checkFrame("afterAbort");

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
